// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared FSM state type and width helper for the NN address sequencer
package nn_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, BOOT, DONE} state_e;
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/nn_loop_counter.sv
// nn_loop_counter: wrapping 0..MAX-1 counter with enable, sync clear and wrap flag
module nn_loop_counter import nn_seq_pkg::*; #(
  parameter int MAX = 2,
  parameter int W = clog2_min1(MAX)
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         clr_in,
  input  logic         en_in,
  output logic [W-1:0] cnt_out,
  output logic         wrap_out
);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_out = cnt_q == W'(MAX - 1);
  assign cnt_out = cnt_q;
  always_comb cnt_d = clr_in ? '0 : en_in ? (wrap_out ? '0 : cnt_q + W'(1)) : cnt_q;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/nn_addr_sequencer.sv
// nn_addr_sequencer: walks the n/k/j loop nest issuing A, NN-weight and b addresses with bootstrap pauses
module nn_addr_sequencer import nn_seq_pkg::*; #(
  parameter int DEPTH = 100,
  parameter int K = 502,
  parameter int NN_OUT = 10,
  parameter int BOOT_PERIOD = 4,
  parameter int A_W = clog2_min1(DEPTH * (K / 2)),
  parameter int NN_W = clog2_min1(DEPTH * NN_OUT),
  parameter int B_W = clog2_min1(NN_OUT * (K / 2)),
  localparam int HALF_K = K / 2,
  localparam int NW = clog2_min1(DEPTH),
  localparam int KW = clog2_min1(HALF_K),
  localparam int JW = clog2_min1(NN_OUT),
  localparam int PW = clog2_min1(BOOT_PERIOD)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            start_in,
  input  logic            abort_in,
  input  logic            boot_en_in,
  input  logic            addr_ready_in,
  input  logic            boot_ack_in,
  output logic            addr_valid_out,
  output logic [A_W-1:0]  a_addr_out,
  output logic [NN_W-1:0] nn_addr_out,
  output logic [B_W-1:0]  b_addr_out,
  output logic [NW-1:0]   n_idx_out,
  output logic [KW-1:0]   k_idx_out,
  output logic [JW-1:0]   j_idx_out,
  output logic            last_j_out,
  output logic            last_k_out,
  output logic            last_out,
  output logic            boot_req_out,
  output logic            busy_out,
  output logic            done_out
);
  state_e state_q, state_d;
  logic boot_en_q, boot_en_d;
  logic [PW-1:0] brow_q, brow_d;
  logic [A_W-1:0] a_q, a_d;
  logic [NN_W-1:0] nn_q, nn_d;
  logic [B_W-1:0] b_q, b_d;
  logic run, accept, start_ok, clr, j_wrap, k_wrap, n_wrap, row_end, final_beat, boot_hit;
  assign run = state_q == RUN;
  assign accept = run && addr_ready_in;
  assign start_ok = state_q == IDLE && start_in;
  assign clr = abort_in || start_ok;
  assign row_end = accept && j_wrap && k_wrap;
  assign final_beat = row_end && n_wrap;
  // brow_q counts completed rows modulo BOOT_PERIOD so no divider is needed
  assign boot_hit = row_end && !n_wrap && boot_en_q && brow_q == PW'(BOOT_PERIOD - 1);
  nn_loop_counter #(.MAX(NN_OUT), .W(JW)) u_j (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr), .en_in(accept),
    .cnt_out(j_idx_out), .wrap_out(j_wrap)
  );
  nn_loop_counter #(.MAX(HALF_K), .W(KW)) u_k (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr), .en_in(accept && j_wrap),
    .cnt_out(k_idx_out), .wrap_out(k_wrap)
  );
  nn_loop_counter #(.MAX(DEPTH), .W(NW)) u_n (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr), .en_in(row_end),
    .cnt_out(n_idx_out), .wrap_out(n_wrap)
  );
  always_comb begin
    state_d = abort_in ? IDLE
            : start_ok ? RUN
            : final_beat ? DONE
            : boot_hit ? BOOT
            : (state_q == BOOT && boot_ack_in) ? RUN
            : state_q == DONE ? IDLE
            : state_q;
    boot_en_d = start_ok ? boot_en_in : boot_en_q;
    brow_d = clr ? '0 : row_end ? (brow_q == PW'(BOOT_PERIOD - 1) ? '0 : brow_q + PW'(1)) : brow_q;
    a_d = (clr || final_beat) ? '0 : (accept && j_wrap) ? a_q + A_W'(1) : a_q;
    // nn rewinds to the row base on a k step; crossing a row it simply continues
    nn_d = (clr || final_beat) ? '0
         : accept ? ((j_wrap && !k_wrap) ? nn_q - NN_W'(NN_OUT - 1) : nn_q + NN_W'(1))
         : nn_q;
    b_d = (clr || final_beat) ? '0
        : accept ? (j_wrap ? (k_wrap ? '0 : B_W'(k_idx_out) + B_W'(1)) : b_q + B_W'(HALF_K))
        : b_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= IDLE;
      boot_en_q <= 1'b0;
      brow_q <= '0;
      a_q <= '0;
      nn_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      boot_en_q <= boot_en_d;
      brow_q <= brow_d;
      a_q <= a_d;
      nn_q <= nn_d;
      b_q <= b_d;
    end
  assign addr_valid_out = run;
  assign boot_req_out = state_q == BOOT;
  assign busy_out = state_q != IDLE;
  assign done_out = state_q == DONE;
  assign last_j_out = run && j_wrap;
  assign last_k_out = last_j_out && k_wrap;
  assign last_out = last_k_out && n_wrap;
  assign a_addr_out = a_q;
  assign nn_addr_out = nn_q;
  assign b_addr_out = b_q;
endmodule

// File: tb/tb_nn_addr_sequencer.sv
// tb_nn_addr_sequencer: randomized directed checks of the sequencer against a loop-nest reference model
module tb_nn_addr_sequencer;
  localparam int DEPTH = 4, K = 6, NO = 2, BP = 2, HK = K / 2, TOT = DEPTH * HK * NO;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, abort_s, boot_en, ready, ack;
  logic valid, lj, lk, last, breq, busy, done;
  logic [3:0] a;
  logic [2:0] nn, b;
  logic [1:0] n_i, k_i;
  logic [0:0] j_i;
  logic start1, ready1;
  logic valid1, lj1, lk1, last1, breq1, busy1, done1;
  logic [0:0] a1, nn1, b1, n1, k1, j1;
  int total = 0, bad = 0;

  nn_addr_sequencer #(.DEPTH(DEPTH), .K(K), .NN_OUT(NO), .BOOT_PERIOD(BP)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .abort_in(abort_s), .boot_en_in(boot_en),
    .addr_ready_in(ready), .boot_ack_in(ack), .addr_valid_out(valid), .a_addr_out(a),
    .nn_addr_out(nn), .b_addr_out(b), .n_idx_out(n_i), .k_idx_out(k_i), .j_idx_out(j_i),
    .last_j_out(lj), .last_k_out(lk), .last_out(last), .boot_req_out(breq), .busy_out(busy),
    .done_out(done)
  );
  nn_addr_sequencer #(.DEPTH(1), .K(2), .NN_OUT(1), .BOOT_PERIOD(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .abort_in(1'b0), .boot_en_in(1'b1),
    .addr_ready_in(ready1), .boot_ack_in(1'b0), .addr_valid_out(valid1), .a_addr_out(a1),
    .nn_addr_out(nn1), .b_addr_out(b1), .n_idx_out(n1), .k_idx_out(k1), .j_idx_out(j1),
    .last_j_out(lj1), .last_k_out(lk1), .last_out(last1), .boot_req_out(breq1), .busy_out(busy1),
    .done_out(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_layer(input logic ben, input int pct, input int ack_delay, input int abort_at);
    int idx, bcnt, dut_eps, dut_bcyc, exp_eps, en, ek, ej;
    logic in_boot, ev, acc, prev_breq, qual;
    logic [17:0] eb;
    exp_eps = 0;
    if (ben) for (int r = 0; r < DEPTH - 1; r++) if ((r + 1) % BP == 0) exp_eps++;
    boot_en = ben;
    start = 1'b1;
    step();
    start = 1'b0;
    boot_en = ~ben;
    idx = 0; bcnt = 0; dut_eps = 0; dut_bcyc = 0; in_boot = 1'b0; prev_breq = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ev = idx < TOT && !in_boot;
      chk("valid", valid, ev);
      chk("boot_req", breq, in_boot);
      if (breq) begin
        dut_bcyc++;
        if (!prev_breq) dut_eps++;
      end
      prev_breq = breq;
      en = idx / (HK * NO);
      ek = (idx / NO) % HK;
      ej = idx % NO;
      if (ev) begin
        eb = {2'(en), 2'(ek), 1'(ej), 4'(en * HK + ek), 3'(en * NO + ej), 3'(ej * HK + ek),
              ej == NO - 1, ej == NO - 1 && ek == HK - 1, idx == TOT - 1};
        chk($sformatf("beat%0d", idx), {n_i, k_i, j_i, a, nn, b, lj, lk, last}, eb);
      end
      if (idx == TOT) break;
      if (ev && idx == abort_at) begin
        abort_s = 1'b1;
        ready = 1'b1;
        step();
        abort_s = 1'b0;
        ready = 1'b0;
        chk("abort_out", {valid, breq, done, busy}, 0);
        chk("abort_idx", {n_i, k_i, j_i}, 0);
        step();
        chk("abort_nodone", {done, busy}, 0);
        return;
      end
      ready = $urandom_range(99) < pct;
      if (in_boot) begin
        bcnt++;
        ack = bcnt >= ack_delay;
      end else ack = 1'($urandom_range(1));
      acc = ev && ready;
      step();
      if (acc) begin
        qual = ben && ek == HK - 1 && ej == NO - 1 && en != DEPTH - 1 && (en + 1) % BP == 0;
        idx++;
        if (qual) begin
          in_boot = 1'b1;
          bcnt = 0;
        end
      end else if (in_boot && ack) in_boot = 1'b0;
    end
    chk("beats_accepted", idx, TOT);
    chk("done", done, 1);
    chk("boot_episodes", dut_eps, exp_eps);
    chk("boot_cycles", dut_bcyc, exp_eps * (ack_delay < 1 ? 1 : ack_delay));
    ready = 1'b0;
    ack = 1'b0;
    step();
    chk("done_pulse", {done, busy}, 0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; start = 1'b0; abort_s = 1'b0; boot_en = 1'b0; ready = 1'b0; ack = 1'b0;
    start1 = 1'b0; ready1 = 1'b0;
    #12;
    chk("reset0", {valid, a, nn, b, n_i, k_i, j_i, lj, lk, last, breq, busy, done}, 0);
    chk("reset1", {valid1, a1, nn1, b1, n1, k1, j1, lj1, lk1, last1, breq1, busy1, done1}, 0);
    rst_n = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("start_ignored_idle", busy, 0);
    run_layer(1'b1, 100, 1, -1);
    run_layer(1'b1, 50, 1, -1);
    run_layer(1'b1, 100, 7, -1);
    run_layer(1'b0, 100, 1, -1);
    run_layer(1'b1, 100, 1, 10);
    run_layer(1'b1, 60, 3, -1);
    boot_en = 1'b1;
    start = 1'b1;
    ready = 1'b1;
    ack = 1'b0;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (breq) seen = 1'b1;
      else step();
    end
    chk("reach_boot", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {valid, a, nn, b, n_i, k_i, j_i, lj, lk, last, breq, busy, done}, 0);
    rst_n = 1'b1;
    ready = 1'b0;
    step();
    chk("after_reset", {valid, breq, busy, done}, 0);
    start1 = 1'b1;
    ready1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("degen_beat", {valid1, lj1, lk1, last1, a1, nn1, b1, n1, k1, j1}, 10'b1111_000000);
    step();
    chk("degen_done", {done1, valid1, breq1}, 3'b100);
    step();
    chk("degen_idle", {done1, busy1}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nn_addr_sequencer.md
Name: nn_addr_sequencer

Overview:
- Next-generation address sequencer for the encrypted NN layer engine: walks the row (N) / key-half (k) / output-neuron (j) loop nest and issues A, NN-weight and b-accumulator addresses.
- Compared with the current generation it adds:
  - fully parametrised widths;
  - a valid/ready back-pressure handshake;
  - a request/acknowledge bootstrap pause with a programmable period;
  - start/abort control and per-beat last flags.
- Sits between the layer controller and the BRAM read ports / MAC datapath.

Parameters:
- DEPTH, 100, number of outer rows N (≥1)
- K, 502, LWE dimension; inner k loop runs HALF_K = K/2 (≥1)
- NN_OUT, 10, output neurons per row, innermost loop (≥1)
- BOOT_PERIOD, 4, rows between bootstrap pauses (≥1)
- A_W, $clog2(DEPTH*(K/2)), width of a_addr_out
- NN_W, $clog2(DEPTH*NN_OUT), width of nn_addr_out
- B_W, $clog2(NN_OUT*(K/2)), width of b_addr_out

Ports:
- clk_in, input, 1, clock
- rst_n_in, input, 1, asynchronous active-low reset
- start_in, input, 1, pulse; accepted only in IDLE
- abort_in, input, 1, synchronous return to IDLE from any state
- boot_en_in, input, 1, sampled at start; 0 disables bootstrap pauses
- addr_ready_in, input, 1, consumer accepts the current beat
- boot_ack_in, input, 1, bootstrap unit finished
- addr_valid_out, output, 1, beat valid
- a_addr_out, output, A_W, n*HALF_K + k
- nn_addr_out, output, NN_W, n*NN_OUT + j
- b_addr_out, output, B_W, j*HALF_K + k
- n_idx_out / k_idx_out / j_idx_out, output, $clog2 of each bound (min 1), raw indices
- last_j_out, output, 1, j == NN_OUT-1
- last_k_out, output, 1, last_j and k == HALF_K-1 (row end)
- last_out, output, 1, final beat of layer
- boot_req_out, output, 1, bootstrap request
- busy_out, output, 1, state != IDLE
- done_out, output, 1, one-cycle pulse after final beat accepted

Behaviour:
- Reset (async, rst_n_in low): state IDLE; all outputs 0; indices and addresses 0; latched boot_en 0.
- FSM states: IDLE, RUN, BOOT, DONE.
- IDLE:
  - start_in → RUN next cycle; indices and addresses cleared; boot_en_in latched.
  - start_in outside IDLE is ignored.
- RUN:
  - addr_valid_out = 1. A beat is accepted when addr_valid_out && addr_ready_in.
  - All beat outputs (addresses, indices, last flags) are registered and held stable while valid && !ready.
  - On accept, advance j; on j wrap, advance k; on k wrap, advance n.
  - Addresses are updated incrementally with adders only, no multipliers:
    - a_addr += 1 on k advance;
    - nn_addr += 1 per beat, and the n advance makes it continuous;
    - b_addr += HALF_K per j step, reset to the new k on j wrap.
  - First beat valid the cycle after start: 1-cycle latency.
- Bootstrap:
  - Condition: accepted beat has last_k_out, (n+1) % BOOT_PERIOD == 0, n != DEPTH-1, and latched boot_en = 1. Then next state is BOOT.
  - In BOOT: addr_valid_out = 0, boot_req_out = 1, held until boot_ack_in is sampled high; then return to RUN at (n+1,0,0).
  - boot_ack_in while not in BOOT is ignored.
  - boot_ack_in may arrive in the first BOOT cycle: minimum 1 BOOT cycle.
- Completion: accepted beat with last_out → DONE. DONE lasts one cycle with done_out = 1 and valid 0, then IDLE.
- abort_in: has priority over every transition, including simultaneous start or accept. Next cycle is IDLE, valid / boot_req / done are 0, indices are cleared. No done pulse.
- Degenerate sizes:
  - DEPTH=1 means no bootstrap ever.
  - NN_OUT=1 means every beat has last_j_out.
  - HALF_K=1 means every last_j beat is a row end.
- No beat is lost or duplicated under arbitrary addr_ready_in patterns. Total accepted beats = DEPTH*HALF_K*NN_OUT.

Decomposition:
- Package nn_seq_pkg: state enum (IDLE, RUN, BOOT, DONE) and a width helper function clog2_min1.
- One sub-module, nn_loop_counter: wrapping counter with enable, synchronous clear, parameter MAX, and wrap output. Instantiated three times and chained via wrap&&accept.

Test Plan:
- Small config (DEPTH=4, K=6, NN_OUT=2, BOOT_PERIOD=2, boot_en=1, ready always 1), start → 24 beats.
  - First beats are (n,k,j) = (0,0,0), (0,0,1), (0,1,0).
  - Beat (1,2,1): a=5, nn=3, b=5, last_k=1.
  - Exactly one BOOT after row 1; none after row 3.
  - done_out pulses once.
- Same config with ready random at 50% → identical beat/address sequence; outputs stable while stalled; 24 accepts.
- boot_ack_in delayed 7 cycles → boot_req_out high 7 cycles, valid 0 throughout; resume at (2,0,0), a=6, nn=4, b=0.
- boot_en_in=0 at start → no BOOT state; 24 consecutive beats with ready=1.
- abort_in at beat 10, concurrent with accept → IDLE next cycle, no done; a new start restarts at (0,0,0).
- rst_n_in low mid-BOOT → outputs 0 immediately (async), IDLE after release; DEPTH=1, HALF_K=1, NN_OUT=1 → single beat with all last flags = 1, then done.
